reg_bank_arbiter: RTL
=====================

Name: reg_bank_arbiter

Overview:
Sequencer and arbiter for a bank of NREG 16-bit hold/load registers that share one AND-gated output bus. Two requesters, A (ALU writeback) and B (load/store path), issue single-register read or write transactions. The block grants them round-robin, drives each register's per-register R_W (0 = load, 1 = hold) and Ea (output enable) strobes, and returns read data over a one-cycle ack handshake. It sits between the ALU/control path and the register bank; the bank's gated outputs are OR-reduced externally into bank_q.

Parameters:
NREG, 4, number of registers in the bank (2..16)
AW, 2, address width; must satisfy 2**AW >= NREG
DW, 16, data width

Ports:
CLK  in  1  system clock, all state updates on rising edge
CLR  in  1  reset, synchronous, active-high
req_a  in  1  requester A transaction request, held until ack_a
we_a  in  1  A: 1 = write, 0 = read
addr_a  in  AW  A register address
wdata_a  in  DW  A write data
ack_a  out  1  A completion pulse, one cycle
req_b, we_b, addr_b, wdata_b, ack_b  same as A, for requester B
rdata  out  DW  read data, valid while rvalid=1
rvalid  out  1  high with ack_x on a completed read
err  out  1  high with ack_x when the address is >= NREG
busy  out  1  high in any state other than IDLE
reg_rw  out  NREG  per-register R_W strobe to the bank (0 = load, 1 = hold)
reg_ea  out  NREG  per-register output enable to the bank
reg_d  out  DW  shared write data to the bank
bank_q  in  DW  OR of all bank gated outputs

Behaviour:
- Interface is decided: one clock, CLK; reset CLR is synchronous and active-high.
- Reset values:
  - state = IDLE, rr pointer favours A.
  - ack_a = ack_b = rvalid = err = busy = 0, rdata = 0.
  - reg_rw = all 1s, reg_ea = 0, reg_d = 0.
- While CLR = 1, reg_rw is forced to all 1s and reg_ea to 0 combinationally, regardless of state. A reset landing in WRITE therefore never loads the bank.
- FSM states: IDLE, WRITE, READ, ACK.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the requester not granted last.
  - On grant, latch we, addr, wdata and the grant id. Go to WRITE if we = 1, otherwise READ.
- WRITE (exactly 1 cycle):
  - reg_d = latched wdata.
  - reg_rw[addr] = 0 and all other bits 1, so the bank loads at the edge ending this cycle.
  - If addr >= NREG, every reg_rw bit stays 1 (no load) and err is set.
  - Next state: ACK.
- READ (exactly 1 cycle):
  - reg_ea[addr] = 1.
  - rdata is captured from bank_q at the edge ending this cycle.
  - If addr >= NREG, reg_ea stays 0, rdata is captured as 0, and err is set.
  - Next state: ACK.
- ACK (exactly 1 cycle):
  - ack of the granted requester = 1; rvalid = 1 for reads.
  - err is high if latched; rdata holds its value.
  - Update the rr pointer to the granted requester. Next state: IDLE.
- Latency: request sampled at IDLE edge N → strobe cycle N+1 → ack cycle N+2. One transaction completes per 3 cycles.
- The requester must deassert req in the cycle after ack. A req still high in IDLE is a new transaction.
- Request inputs are ignored outside IDLE. Changing addr, wdata or we after grant has no effect.
- rdata holds until the next read capture. err and rvalid are 0 outside ACK.
- reg_d = 0 outside WRITE. At most one reg_rw bit is 0 and at most one reg_ea bit is 1 in any cycle.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WRITE, READ, ACK);
  - RW_LOAD = 0 and RW_HOLD = 1 constants;
  - grant-id constants GNT_A and GNT_B.
- One sub-module: rr_arbiter2, a two-way round-robin picker. It takes req[1:0] and the last-grant bit, and returns a one-hot grant. It is purely combinational; the pointer flop lives in the parent.

Test Plan:
- Reset then A writes 0xBEEF to addr 2 → cycle N+1: reg_rw = 4'b1011, reg_d = 0xBEEF. Cycle N+2: ack_a = 1, err = 0.
- A reads addr 2 with the bank model returning 0xBEEF → reg_ea = 4'b0100 in cycle N+1. Cycle N+2: ack_a = 1, rvalid = 1, rdata = 0xBEEF.
- req_a and req_b both high continuously after reset → grants alternate A, B, A, B. ack_a and ack_b arrive every 3 cycles, alternating.
- NREG = 3: write to addr 3 → reg_rw stays all 1s and ack with err = 1. Read from addr 3 → rdata = 0, rvalid = 1, err = 1.
- CLR asserted during a WRITE cycle → reg_rw all 1s that cycle and the bank is unchanged. Next cycle: IDLE, busy = 0, no ack. A then wins a tie with B.
- B writes 0x1234 to addr 0, then A reads addr 0 → rdata = 0x1234. busy is high for exactly 2 cycles of each transaction.

Source files
------------

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and constants for the register-bank sequencer/arbiter.
package reg_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    ACK
  } state_t;

  localparam logic RW_LOAD = 1'b0;
  localparam logic RW_HOLD = 1'b1;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the requester not granted last.
module rr_arbiter2
  import reg_bank_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == GNT_A) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Sequencer/arbiter for a bank of hold/load registers on a shared AND-gated bus.
// Two requesters are granted round-robin; each transaction is grant, one strobe cycle, one ack cycle.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int DW   = 16
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            req_a,
  input  logic            we_a,
  input  logic [AW-1:0]   addr_a,
  input  logic [DW-1:0]   wdata_a,
  output logic            ack_a,
  input  logic            req_b,
  input  logic            we_b,
  input  logic [AW-1:0]   addr_b,
  input  logic [DW-1:0]   wdata_b,
  output logic            ack_b,
  output logic [DW-1:0]   rdata,
  output logic            rvalid,
  output logic            err,
  output logic            busy,
  output logic [NREG-1:0] reg_rw,
  output logic [NREG-1:0] reg_ea,
  output logic [DW-1:0]   reg_d,
  input  logic [DW-1:0]   bank_q
);

  localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

  state_t          state;
  logic            last_gnt;
  logic            gnt_id;
  logic            bad_q;
  logic [NREG-1:0] rw_q;
  logic [NREG-1:0] ea_q;
  logic [DW-1:0]   d_q;

  logic [1:0]      gnt;
  logic            sel_b;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_ok;
  logic [NREG-1:0] sel_hot;
  logic [NREG-1:0] sel_rw;

  rr_arbiter2 u_arb (
    .req  ({req_b, req_a}),
    .last (last_gnt),
    .gnt  (gnt)
  );

  assign sel_b     = gnt[1];
  assign sel_we    = sel_b ? we_b    : we_a;
  assign sel_addr  = sel_b ? addr_b  : addr_a;
  assign sel_wdata = sel_b ? wdata_b : wdata_a;
  assign sel_ok    = {1'b0, sel_addr} < NREG_L;

  // An out-of-range address matches no bit, so it neither loads nor enables anything.
  always_comb begin
    sel_hot = '0;
    sel_rw  = {NREG{RW_HOLD}};
    for (int unsigned i = 0; i < NREG; i++) begin
      if (AW'(i) == sel_addr) begin
        sel_hot[i] = 1'b1;
        sel_rw[i]  = RW_LOAD;
      end
    end
  end

  // Strobes are registered at grant so they are glitch-free for the whole strobe cycle.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= IDLE;
      last_gnt <= GNT_B;
      gnt_id   <= GNT_A;
      bad_q    <= 1'b0;
      rw_q     <= {NREG{RW_HOLD}};
      ea_q     <= '0;
      d_q      <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
    end else begin
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      rvalid <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            gnt_id <= sel_b ? GNT_B : GNT_A;
            bad_q  <= !sel_ok;
            if (sel_we) begin
              rw_q  <= sel_rw;
              d_q   <= sel_wdata;
              state <= WRITE;
            end else begin
              ea_q  <= sel_hot;
              state <= READ;
            end
          end
        end
        WRITE: begin
          rw_q  <= {NREG{RW_HOLD}};
          d_q   <= '0;
          ack_a <= (gnt_id == GNT_A);
          ack_b <= (gnt_id == GNT_B);
          err   <= bad_q;
          state <= ACK;
        end
        READ: begin
          ea_q   <= '0;
          rdata  <= bad_q ? '0 : bank_q;
          rvalid <= 1'b1;
          ack_a  <= (gnt_id == GNT_A);
          ack_b  <= (gnt_id == GNT_B);
          err    <= bad_q;
          state  <= ACK;
        end
        ACK: begin
          last_gnt <= gnt_id;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset overrides the bank strobes immediately, so a reset mid-WRITE cannot load.
  assign reg_rw = CLR ? {NREG{RW_HOLD}} : rw_q;
  assign reg_ea = CLR ? '0 : ea_q;
  assign reg_d  = d_q;
  assign busy   = (state != IDLE);

endmodule
